// File: rtl/mbs_fsk_multi.sv
// ----------------------------------------------------------------------------
// mbs_fsk_multi
//   Multi-channel binary FSK transmitter. Each channel takes a FRAME_W-bit
//   frame and shifts it out MSB first. Each bit lasts a programmable number
//   of clock cycles. The output is a square wave whose half-period is
//   div_mark for a 1 bit and div_space for a 0 bit. The tone phase runs
//   continuously across bit boundaries and across the IDLE->SEND handover.
//   The channels share the clock and the configuration inputs. They share
//   no state.
//
// Ports
//   CLK         in   clock; all state changes on the rising edge
//   RESET       in   synchronous active-high reset
//   div_mark    in   [DIV_W]    tone half-period (cycles) for bit value 1
//   div_space   in   [DIV_W]    tone half-period (cycles) for bit value 0
//   baud_div    in   [BAUD_W]   cycles per transmitted bit
//   idle_mark   in   1: idle channel emits mark tone, 0: idle output low
//   load_valid  in   [NCH]      per-channel frame-load request
//   load_data   in   [NCH*FRAME_W] channel c frame at [c*FRAME_W +: FRAME_W]
//   load_ready  out  [NCH]      channel is IDLE and accepts a frame
//   busy        out  [NCH]      channel is transmitting
//   done        out  [NCH]      one-cycle pulse after the last bit of a frame
//   fsk_out     out  [NCH]      square-wave FSK output
// ----------------------------------------------------------------------------
module mbs_fsk_multi #(
    parameter int NCH     = 2,
    parameter int DIV_W   = 16,
    parameter int BAUD_W  = 16,
    parameter int FRAME_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DIV_W-1:0]         div_mark,
    input  logic [DIV_W-1:0]         div_space,
    input  logic [BAUD_W-1:0]        baud_div,
    input  logic                     idle_mark,
    input  logic [NCH-1:0]           load_valid,
    input  logic [NCH*FRAME_W-1:0]   load_data,
    output logic [NCH-1:0]           load_ready,
    output logic [NCH-1:0]           busy,
    output logic [NCH-1:0]           done,
    output logic [NCH-1:0]           fsk_out
);

    localparam int              IDX_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Per-channel state
    state_t             r_state     [NCH];
    logic [FRAME_W-1:0] r_frame     [NCH];
    logic [DIV_W-1:0]   r_div_mark  [NCH];
    logic [DIV_W-1:0]   r_div_space [NCH];
    logic [BAUD_W-1:0]  r_baud      [NCH];
    logic [BAUD_W-1:0]  r_baud_cnt  [NCH];
    logic [IDX_W-1:0]   r_bit_idx   [NCH];
    logic [DIV_W-1:0]   r_tone_cnt  [NCH];
    logic [NCH-1:0]     r_fsk;
    logic [NCH-1:0]     r_done;

    // Per-channel decode
    state_t             w_state_nxt [NCH];
    logic [NCH-1:0]     w_accept;
    logic [NCH-1:0]     w_bit_end;
    logic [NCH-1:0]     w_frame_end;
    logic [NCH-1:0]     w_tone_wrap;
    logic [BAUD_W-1:0]  w_baud_last [NCH];
    logic [DIV_W-1:0]   w_div_sel   [NCH];
    logic [DIV_W-1:0]   w_div_last  [NCH];

    // ------------------------------------------------------------------
    // Shared decode: accept, bit/frame boundaries, tone wrap.
    // A zero divider behaves as 1. Its terminal count (D-1) is then 0.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional logic. A path that leaves a signal unassigned would
        // infer a latch.
        w_accept    = '0;
        w_bit_end   = '0;
        w_frame_end = '0;
        w_tone_wrap = '0;
        w_baud_last = '{default: '0};
        w_div_sel   = '{default: '0};
        w_div_last  = '{default: '0};
        for (int c = 0; c < NCH; c++) begin
            w_accept[c]    = load_valid[c] && (r_state[c] == S_IDLE);
            w_baud_last[c] = (r_baud[c] == '0) ? '0 : r_baud[c] - BAUD_W'(1);
            w_bit_end[c]   = (r_baud_cnt[c] >= w_baud_last[c]);
            w_frame_end[c] = (r_state[c] == S_SEND) && w_bit_end[c] &&
                             (r_bit_idx[c] == LAST_IDX);

            // Latched dividers while sending. The live mark divider
            // drives the idle tone.
            if (r_state[c] == S_SEND) begin
                w_div_sel[c] = r_frame[c][LAST_IDX - r_bit_idx[c]] ?
                               r_div_mark[c] : r_div_space[c];
            end else begin
                w_div_sel[c] = div_mark;
            end
            w_div_last[c]  = (w_div_sel[c] == '0) ? '0 : w_div_sel[c] - DIV_W'(1);
            // >= instead of == : a divider that shrinks at a bit boundary
            // still wraps on the next cycle and does not run off to overflow.
            w_tone_wrap[c] = (r_tone_cnt[c] >= w_div_last[c]);
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is written with non-blocking assignments
        // only. All registers then update together on the edge, regardless
        // of statement order.
        if (RESET) begin
            for (int c = 0; c < NCH; c++) r_state[c] <= S_IDLE;
        end else begin
            for (int c = 0; c < NCH; c++) r_state[c] <= w_state_nxt[c];
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        for (int c = 0; c < NCH; c++) begin
            case (r_state[c])
                S_IDLE:  if (w_accept[c])    w_state_nxt[c] = S_SEND;
                S_SEND:  if (w_frame_end[c]) w_state_nxt[c] = S_IDLE;
                default: w_state_nxt[c] = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        load_ready = '0;
        busy       = '0;
        for (int c = 0; c < NCH; c++) begin
            load_ready[c] = (r_state[c] == S_IDLE);
            busy[c]       = (r_state[c] == S_SEND);
        end
        done    = r_done;
        fsk_out = r_fsk;
    end

    // ------------------------------------------------------------------
    // Datapath: frame/config capture, baud and bit counters, tone generator
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the latched frame and divider copies are reset as well.
            // They are few flops, and after reset nothing in the design
            // depends on values left from before the reset.
            for (int c = 0; c < NCH; c++) begin
                r_frame[c]     <= '0;
                r_div_mark[c]  <= '0;
                r_div_space[c] <= '0;
                r_baud[c]      <= '0;
                r_baud_cnt[c]  <= '0;
                r_bit_idx[c]   <= '0;
                r_tone_cnt[c]  <= '0;
            end
            r_fsk  <= '0;
            r_done <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_done[c] <= w_frame_end[c];

                if (w_accept[c]) begin
                    // Snapshot the config so later input changes cannot
                    // disturb the frame in flight. The output level is held,
                    // so the tone phase carries into SEND.
                    r_frame[c]     <= load_data[c*FRAME_W +: FRAME_W];
                    r_div_mark[c]  <= div_mark;
                    r_div_space[c] <= div_space;
                    r_baud[c]      <= baud_div;
                    r_baud_cnt[c]  <= '0;
                    r_bit_idx[c]   <= '0;
                    r_tone_cnt[c]  <= '0;
                end else begin
                    if (r_state[c] == S_SEND) begin
                        if (w_bit_end[c]) begin
                            r_baud_cnt[c] <= '0;
                            r_bit_idx[c]  <= r_bit_idx[c] + IDX_W'(1);
                        end else begin
                            r_baud_cnt[c] <= r_baud_cnt[c] + BAUD_W'(1);
                        end
                    end

                    // Tone counter is never cleared at bit boundaries.
                    if ((r_state[c] == S_SEND) || idle_mark) begin
                        if (w_tone_wrap[c]) begin
                            r_tone_cnt[c] <= '0;
                            r_fsk[c]      <= ~r_fsk[c];
                        end else begin
                            r_tone_cnt[c] <= r_tone_cnt[c] + DIV_W'(1);
                        end
                    end else begin
                        r_tone_cnt[c] <= '0;
                        r_fsk[c]      <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mbs_fsk_multi.sv
// ----------------------------------------------------------------------------
// tb_mbs_fsk_multi
//   Directed bench for mbs_fsk_multi (NCH=2, FRAME_W=8). Each scenario drives
//   a short input sequence and captures fsk_out/busy/done cycle by cycle from
//   the accept cycle. It then compares the capture with hand-derived
//   waveforms. Capture vectors hold the cycle-0 sample in their MSB.
// ----------------------------------------------------------------------------
module tb_mbs_fsk_multi;

    logic        CLK;
    logic        RESET;
    logic [15:0] div_mark;
    logic [15:0] div_space;
    logic [15:0] baud_div;
    logic        idle_mark;
    logic [1:0]  load_valid;
    logic [15:0] load_data;
    logic [1:0]  load_ready;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  fsk_out;

    int checks = 0;
    int errors = 0;

    logic [63:0] cap0, cap1;
    logic [63:0] bc0, bc1;
    logic [63:0] dc0, dc1;
    logic [63:0] da0, da1;
    logic [63:0] cyc;

    // 0xA5 with B=4, mark D=1, space D=2, starting level 0, cycles 0..32
    localparam logic [63:0] EXP_A5 = 64'b0_1010_0110_1010_0110_0110_1010_0110_1010;

    mbs_fsk_multi #(
        .NCH     (2),
        .DIV_W   (16),
        .BAUD_W  (16),
        .FRAME_W (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .div_mark   (div_mark),
        .div_space  (div_space),
        .baud_div   (baud_div),
        .idle_mark  (idle_mark),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .busy       (busy),
        .done       (done),
        .fsk_out    (fsk_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        cap0 = '0; cap1 = '0;
        bc0  = '0; bc1  = '0;
        dc0  = '0; dc1  = '0;
        da0  = '0; da1  = '0;
        cyc  = '0;
    endtask

    // Sample the current cycle, then advance. Repeats n times.
    task automatic run_window(input int n);
        for (int k = 0; k < n; k++) begin
            cap0 = {cap0[62:0], fsk_out[0]};
            cap1 = {cap1[62:0], fsk_out[1]};
            if (busy[0]) bc0++;
            if (busy[1]) bc1++;
            if (done[0]) begin dc0++; da0 = cyc; end
            if (done[1]) begin dc1++; da1 = cyc; end
            cyc++;
            tick();
        end
    endtask

    initial begin
        RESET      = 1'b1;
        div_mark   = 16'd1;
        div_space  = 16'd2;
        baud_div   = 16'd4;
        idle_mark  = 1'b0;
        load_valid = 2'b00;
        load_data  = 16'h0000;
        clear_cap();

        // ---------------- reset state ----------------
        tick();
        check("rst_load_ready", 64'(load_ready), 64'h3);
        check("rst_busy",       64'(busy),       64'h0);
        check("rst_done",       64'(done),       64'h0);
        check("rst_fsk",        64'(fsk_out),    64'h0);
        tick();
        RESET = 1'b0;
        tick();

        // ---------------- 0xA5 on ch0 ----------------
        load_data  = {8'h00, 8'hA5};
        load_valid = 2'b01;
        tick();
        load_valid = 2'b00;
        check("a5_ready_low", 64'(load_ready[0]), 64'h0);
        clear_cap();
        run_window(33);
        check("a5_wave",      cap0, EXP_A5);
        check("a5_busy_cnt",  bc0,  64'd32);
        check("a5_done_cnt",  dc0,  64'd1);
        check("a5_done_at",   da0,  64'd32);
        check("a5_ch1_quiet", cap1 | bc1 | dc1, 64'h0);
        check("a5_done_gone", 64'(done[0]), 64'h0);

        // ---------------- simultaneous load 0xFF / 0x00 ----------------
        load_data  = {8'h00, 8'hFF};
        load_valid = 2'b11;
        tick();
        load_valid = 2'b00;
        check("dual_busy", 64'(busy), 64'h3);
        clear_cap();
        run_window(33);
        check("dual_wave0",  cap0, 64'h0_AAAA_AAAA);
        check("dual_wave1",  cap1, 64'h0_6666_6666);
        check("dual_busy0",  bc0,  64'd32);
        check("dual_busy1",  bc1,  64'd32);
        check("dual_done0",  da0,  64'd32);
        check("dual_done1",  da1,  64'd32);
        check("dual_donecnt", dc0 + dc1, 64'd2);

        // ---------------- zero dividers, back-to-back frames ----------------
        baud_div   = 16'd0;
        div_mark   = 16'd0;
        load_data  = {8'h00, 8'hFF};
        load_valid = 2'b01;
        tick();
        clear_cap();
        run_window(9);
        check("zero_wave",     cap0, 64'h0AA);
        check("zero_busy_cnt", bc0,  64'd8);
        check("zero_done_at",  da0,  64'd8);
        check("b2b_reaccept",  64'(busy[0]), 64'h1);
        load_valid = 2'b00;
        clear_cap();
        run_window(9);
        check("b2b_wave",     cap0, 64'h0AA);
        check("b2b_busy_cnt", bc0,  64'd8);
        check("b2b_done_cnt", dc0,  64'd1);

        // ---------------- config change + load during busy ----------------
        baud_div   = 16'd4;
        div_mark   = 16'd1;
        div_space  = 16'd2;
        load_data  = {8'h00, 8'hA5};
        load_valid = 2'b01;
        tick();
        load_valid = 2'b00;
        clear_cap();
        run_window(5);
        div_mark   = 16'd3;
        div_space  = 16'd5;
        baud_div   = 16'd2;
        load_data  = {8'h00, 8'h3C};
        load_valid = 2'b01;
        run_window(5);
        check("chg_ready_low", 64'(load_ready[0]), 64'h0);
        load_valid = 2'b00;
        run_window(23);
        check("chg_wave",     cap0, EXP_A5);
        check("chg_busy_cnt", bc0,  64'd32);
        check("chg_done_cnt", dc0,  64'd1);
        check("chg_done_at",  da0,  64'd32);

        // ---------------- idle mark tone, phase-continuous accept ----------------
        idle_mark = 1'b1;
        div_mark  = 16'd3;
        div_space = 16'd1;
        baud_div  = 16'd4;
        clear_cap();
        run_window(10);
        check("idle_wave",  cap0, 64'h071);
        check("idle_level", 64'(fsk_out[0]), 64'h1);
        load_data  = {8'h00, 8'h00};
        load_valid = 2'b01;
        tick();
        load_valid = 2'b00;
        check("idle_accept_level", 64'(fsk_out[0]), 64'h1);
        clear_cap();
        run_window(33);
        check("space_wave",     cap0, 64'h1_5555_5555);
        check("space_busy_cnt", bc0,  64'd32);

        idle_mark = 1'b0;
        div_mark  = 16'd1;
        div_space = 16'd2;
        tick();
        check("idle_off_low", 64'(fsk_out[0]), 64'h0);

        // ---------------- reset mid-frame ----------------
        load_data  = {8'h00, 8'hA5};
        load_valid = 2'b01;
        tick();
        load_valid = 2'b00;
        clear_cap();
        run_window(13);
        check("mid_busy", 64'(busy[0]), 64'h1);
        RESET      = 1'b1;
        load_valid = 2'b11;
        tick();
        RESET      = 1'b0;
        load_valid = 2'b00;
        check("abort_busy",  64'(busy),       64'h0);
        check("abort_fsk",   64'(fsk_out),    64'h0);
        check("abort_ready", 64'(load_ready), 64'h3);
        check("abort_done",  64'(done),       64'h0);
        clear_cap();
        run_window(5);
        check("abort_no_done", dc0 + dc1, 64'd0);
        check("abort_idle",    bc0 + bc1, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbs_fsk_multi.md
MBS_FSK_MULTI -- requirements
Module: mbs_fsk_multi

Interface
REQ-001: Parameter NCH, default 2, number of independent FSK channels.
REQ-002: Parameter DIV_W, default 16, width of tone half-period dividers.
REQ-003: Parameter BAUD_W, default 16, width of bit-period divider.
REQ-004: Parameter FRAME_W, default 8, bits per frame.
REQ-005: CLK  input  1  single clock; all state changes on its rising edge.
REQ-006: RESET  input  1  synchronous, active-high reset.
REQ-007: div_mark  input  DIV_W  half-period in CLK cycles for bit value 1.
REQ-008: div_space  input  DIV_W  half-period in CLK cycles for bit value 0.
REQ-009: baud_div  input  BAUD_W  CLK cycles per transmitted bit.
REQ-010: idle_mark  input  1  1: idle channel emits mark tone; 0: idle output held low.
REQ-011: load_valid  input  NCH  per-channel frame-load request.
REQ-012: load_data  input  NCH*FRAME_W  channel c frame at bits [c*FRAME_W +: FRAME_W].
REQ-013: load_ready  output  NCH  channel c is IDLE and accepts a frame.
REQ-014: busy  output  NCH  channel c is transmitting.
REQ-015: done  output  NCH  one-cycle pulse at end of channel c frame.
REQ-016: fsk_out  output  NCH  channel c square-wave FSK output.

Function
REQ-017: Each channel SHALL be an independent FSM with states IDLE and SEND; no state is shared between channels.
REQ-018: load_ready[c] SHALL equal (state==IDLE); busy[c] SHALL equal (state==SEND).
REQ-019: Accept on rising edge where load_valid[c] & load_ready[c]: latch frame, div_mark, div_space, baud_div into channel registers; bit index=0; baud counter=0; tone counter=0; state->SEND.
REQ-020: load_valid[c] while busy[c] SHALL be ignored; no buffering.
REQ-021: Config inputs changing during SEND SHALL NOT affect the frame in flight.
REQ-022: Bits SHALL be sent MSB first; bit k occupies exactly B cycles, B = max(latched baud_div,1).
REQ-023: busy[c] SHALL be high for exactly FRAME_W*B cycles, starting the cycle after accept.
REQ-024: On completing bit FRAME_W-1: state->IDLE, done[c]=1 for one cycle (same cycle load_ready rises).
REQ-025: Tone generation per cycle: D = max(selected divider,1); if tone counter >= D-1 then counter<=0 and fsk_out toggles, else counter increments; output tone = CLK/(2D).
REQ-026: Divider selection: current bit 1 -> div_mark, 0 -> div_space (latched values during SEND; live div_mark during IDLE).
REQ-027: Phase continuity: tone counter and fsk_out SHALL NOT reset at bit boundaries; the >= compare handles a shrinking divider.
REQ-028: IDLE with idle_mark=1: tone runs at live div_mark; IDLE with idle_mark=0: fsk_out=0, tone counter=0.
REQ-029: fsk_out level SHALL carry over unchanged from IDLE into SEND on accept.
REQ-030: Minimum spacing between frames on one channel SHALL be one IDLE cycle (accept possible the cycle after done).
REQ-031: Simultaneous loads on multiple channels SHALL all be accepted in the same cycle.

Reset
REQ-032: RESET high at a clock edge SHALL force every channel to IDLE, counters to 0, fsk_out=0, done=0, busy=0, load_ready=1 on the following cycle.
REQ-033: RESET SHALL take priority over load_valid and abort any frame mid-transmission without a done pulse.

Verification
REQ-034: NCH=2, FRAME_W=8, baud_div=4, div_mark=1, div_space=2, idle_mark=0; load ch0 0xA5 -> busy high 32 cycles, fsk_out toggles every cycle during 1-bits, every 2 cycles during 0-bits, MSB first; done single pulse.
REQ-035: Load ch0 and ch1 same cycle with 0xFF/0x00 -> both accepted, ch0 period 2 cycles, ch1 period 4 cycles, done on both in same cycle.
REQ-036: baud_div=0, div_mark=0 -> treated as 1: busy 8 cycles, mark toggles every cycle.
REQ-037: Change div_mark/baud_div mid-frame -> frame timing and tones unchanged; load_valid during busy ignored.
REQ-038: idle_mark=1, div_mark=3 -> idle output toggles every 3 cycles; load 0x00 with div_space=1 -> no phase reset, level continuous at accept.
REQ-039: Assert RESET at bit 3 of a frame -> next cycle busy=0, fsk_out=0, load_ready=1, no done pulse.
